// File: rtl/seg9_pkg.sv
// Shared types and constants for the 9-digit display update scheduler.
package seg9_pkg;

  localparam int unsigned DIGITS  = 9;
  localparam int unsigned PACK_W  = 72;
  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned REQ_N   = 2;
  localparam int unsigned CNT_W   = 16;

  localparam logic [LEVEL_W-1:0] LEVEL_RST = LEVEL_W'(7);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    GUARD     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seg9_update_sched_if.sv
// Requester and display-controller signals of the update scheduler.
interface seg9_update_sched_if;
  import seg9_pkg::*;

  logic [REQ_N-1:0]   req;
  logic [PACK_W-1:0]  req_data0;
  logic [PACK_W-1:0]  req_data1;
  logic [LEVEL_W-1:0] req_level0;
  logic [LEVEL_W-1:0] req_level1;
  logic               req_on0;
  logic               req_on1;
  logic [REQ_N-1:0]   gnt;
  logic               disp_start;
  logic [PACK_W-1:0]  disp_data;
  logic [LEVEL_W-1:0] disp_level;
  logic               disp_on;
  logic               disp_busy;
  logic               sched_busy;
  logic [CNT_W-1:0]   update_cnt;

  // Requesters and display model side
  modport master (
    output req, req_data0, req_data1, req_level0, req_level1, req_on0, req_on1,
    output disp_busy,
    input  gnt, disp_start, disp_data, disp_level, disp_on, sched_busy, update_cnt
  );

  // Scheduler side
  modport slave (
    input  req, req_data0, req_data1, req_level0, req_level1, req_on0, req_on1,
    input  disp_busy,
    output gnt, disp_start, disp_data, disp_level, disp_on, sched_busy, update_cnt
  );

endinterface

// File: rtl/seg9_tick.sv
// Free-running refresh tick: one-cycle pulse every CLK_FREQ/REFRESH_HZ cycles.
module seg9_tick #(
  parameter int unsigned CLK_FREQ   = 10_000_000,
  parameter int unsigned REFRESH_HZ = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV_RAW = CLK_FREQ / REFRESH_HZ;
  localparam int unsigned DIV     = (DIV_RAW > 1) ? DIV_RAW : 2;
  localparam int unsigned CNT_W   = $clog2(DIV);

  logic [CNT_W-1:0] cnt;

  // Divider counter; tick is registered on the terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/seg9_update_sched.sv
// Arbitrates two requesters onto one display controller and re-sends
// the latched contents periodically.
module seg9_update_sched
  import seg9_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 10_000_000,
  parameter int unsigned REFRESH_HZ = 10
) (
  input logic                clk,
  input logic                rst,
  seg9_update_sched_if.slave bus
);

  state_t state;
  logic   last_gnt;
  logic   refresh_pending;
  logic   tick;
  logic   pick_c;

  seg9_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .REFRESH_HZ(REFRESH_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Round-robin pick: on a tie the last-granted index loses
  always_comb begin
    pick_c = 1'b0;
    if (bus.req == 2'b11) pick_c = ~last_gnt;
    else                  pick_c = bus.req[1];
  end

  // Scheduler FSM with registered outputs and refresh bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_gnt        <= 1'b1;
      refresh_pending <= 1'b1;
      bus.gnt         <= '0;
      bus.disp_start  <= 1'b0;
      bus.disp_data   <= '0;
      bus.disp_level  <= LEVEL_RST;
      bus.disp_on     <= 1'b1;
      bus.sched_busy  <= 1'b0;
      bus.update_cnt  <= '0;
    end else begin
      bus.gnt        <= '0;
      bus.disp_start <= 1'b0;

      // A tick always wins over the clear in START
      if (tick)                refresh_pending <= 1'b1;
      else if (state == START) refresh_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.req) begin
            last_gnt       <= pick_c;
            bus.gnt        <= pick_c ? 2'b10 : 2'b01;
            bus.disp_data  <= pick_c ? bus.req_data1  : bus.req_data0;
            bus.disp_level <= pick_c ? bus.req_level1 : bus.req_level0;
            bus.disp_on    <= pick_c ? bus.req_on1    : bus.req_on0;
            bus.disp_start <= 1'b1;
            bus.sched_busy <= 1'b1;
            state          <= START;
          end else if (refresh_pending) begin
            bus.disp_start <= 1'b1;
            bus.sched_busy <= 1'b1;
            state          <= START;
          end
        end
        START: state <= GUARD;
        GUARD: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!bus.disp_busy) begin
            bus.update_cnt <= bus.update_cnt + CNT_W'(1);
            bus.sched_busy <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
